// File: rtl/pipeline_control_unit_if.sv
// Control/hazard bundle between the pipeline control unit (master) and the ARM datapath (slave).
// The datapath supplies the instruction, ALU flags and register-match vector; the control unit returns every datapath control.
interface pipeline_control_unit_if;
   logic [19:0] InstrD;
   logic [3:0]  ALUFlags;
   logic [4:0]  match;
   logic [1:0]  RegSrcD;
   logic [1:0]  ImmSrcD;
   logic        ALUSrcE;
   logic [3:0]  ALUControlE;
   logic        BranchTakenE;
   logic        MemWriteM;
   logic        RegWriteW;
   logic        MemtoRegW;
   logic        PCSrcW;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic        stallF;
   logic        stallD;
   logic        flushD;
   logic        flushE;

   modport master (
      input  InstrD, ALUFlags, match,
      output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
             RegWriteW, MemtoRegW, PCSrcW, ForwardAE, ForwardBE,
             stallF, stallD, flushD, flushE
   );

   modport slave (
      output InstrD, ALUFlags, match,
      input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
             RegWriteW, MemtoRegW, PCSrcW, ForwardAE, ForwardBE,
             stallF, stallD, flushD, flushE
   );
endinterface

// File: rtl/pipeline_control_unit.sv
// Decode, D->E->M->W control pipeline, condition/flags logic and hazard unit for the 5-stage ARM core.
// D-stage and hazard outputs are combinational; E/M/W controls are one register per stage, never stalled.
module pipeline_control_unit (
   input  logic                     clk,
   input  logic                     reset,
   pipeline_control_unit_if.master  io_pcu
);
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;

   typedef struct packed {
      logic       regw;
      logic       memw;
      logic       memtoreg;
      logic       branch;
      logic       pcsrc;
      logic       alusrc;
      logic [3:0] alu;
      logic [1:0] flagw;
      logic [3:0] cond;
   } ctl_e_t;

   logic [3:0] w_cond_d;
   logic [1:0] w_op_d;
   logic [5:0] w_funct_d;
   logic [3:0] w_rd_d;
   logic [3:0] w_alu_d;
   logic       w_unused_rn;
   ctl_e_t     w_ctl_d;
   logic [1:0] w_regsrc_d;
   logic [1:0] w_immsrc_d;

   ctl_e_t     r_ctl_e;
   logic       r_regw_m;
   logic       r_memw_m;
   logic       r_memtoreg_m;
   logic       r_pcsrc_m;
   logic       r_regw_w;
   logic       r_memtoreg_w;
   logic       r_pcsrc_w;
   logic [3:0] r_flags;

   logic       w_n, w_z, w_c, w_v;
   logic       w_condex_e;
   logic       w_branch_taken_e;
   logic       w_ldr_stall;
   logic       w_pcwr_pend;
   logic       w_flush_e;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   // InstrD carries bits [31:12]: cond, op, funct, Rn, Rd; Rn only matters to the datapath.
   assign w_cond_d    = io_pcu.InstrD[19:16];
   assign w_op_d      = io_pcu.InstrD[15:14];
   assign w_funct_d   = io_pcu.InstrD[13:8];
   assign w_unused_rn = ^io_pcu.InstrD[7:4];
   assign w_rd_d      = io_pcu.InstrD[3:0];

   always_comb begin
      unique case (w_funct_d[4:1])
         4'b0100: w_alu_d = ALU_ADD;
         4'b0010: w_alu_d = ALU_SUB;
         4'b0000: w_alu_d = ALU_AND;
         4'b1100: w_alu_d = ALU_ORR;
         default: w_alu_d = ALU_ADD;
      endcase
   end

   always_comb begin
      w_ctl_d      = '0;
      w_regsrc_d   = 2'b00;
      w_immsrc_d   = 2'b00;
      w_ctl_d.cond = w_cond_d;
      unique case (w_op_d)
         2'b00: begin
            w_ctl_d.regw   = 1'b1;
            w_ctl_d.alusrc = w_funct_d[5];
            w_ctl_d.alu    = w_alu_d;
            if (w_funct_d[0]) begin
               w_ctl_d.flagw = (w_alu_d == ALU_ADD || w_alu_d == ALU_SUB) ? 2'b11 : 2'b10;
            end
         end
         2'b01: begin
            w_ctl_d.alusrc = 1'b1;
            w_immsrc_d     = 2'b01;
            w_ctl_d.alu    = ALU_ADD;
            if (w_funct_d[0]) begin
               w_ctl_d.regw     = 1'b1;
               w_ctl_d.memtoreg = 1'b1;
            end else begin
               w_ctl_d.memw = 1'b1;
               w_regsrc_d   = 2'b10;
            end
         end
         2'b10: begin
            w_ctl_d.branch = 1'b1;
            w_ctl_d.alusrc = 1'b1;
            w_ctl_d.alu    = ALU_ADD;
            w_immsrc_d     = 2'b10;
            w_regsrc_d     = 2'b01;
         end
         default: begin
            w_ctl_d.alu = ALU_ADD;
         end
      endcase
      w_ctl_d.pcsrc = w_ctl_d.regw & (w_rd_d == 4'hF);
   end

   assign {w_n, w_z, w_c, w_v} = r_flags;

   always_comb begin
      unique case (r_ctl_e.cond)
         4'b0000: w_condex_e = w_z;
         4'b0001: w_condex_e = ~w_z;
         4'b0010: w_condex_e = w_c;
         4'b0011: w_condex_e = ~w_c;
         4'b0100: w_condex_e = w_n;
         4'b0101: w_condex_e = ~w_n;
         4'b0110: w_condex_e = w_v;
         4'b0111: w_condex_e = ~w_v;
         4'b1000: w_condex_e = w_c & ~w_z;
         4'b1001: w_condex_e = ~w_c | w_z;
         4'b1010: w_condex_e = ~(w_n ^ w_v);
         4'b1011: w_condex_e = w_n ^ w_v;
         4'b1100: w_condex_e = ~w_z & ~(w_n ^ w_v);
         4'b1101: w_condex_e = w_z | (w_n ^ w_v);
         4'b1110: w_condex_e = 1'b1;
         default: w_condex_e = 1'b0;
      endcase
   end

   assign w_branch_taken_e = r_ctl_e.branch & w_condex_e;

   // A load in Execute whose destination is a source of the Decode instruction cannot be forwarded in time.
   assign w_ldr_stall = io_pcu.match[4] & r_ctl_e.memtoreg & r_ctl_e.regw;
   assign w_pcwr_pend = w_ctl_d.pcsrc | r_ctl_e.pcsrc | r_pcsrc_m;
   assign w_flush_e   = w_ldr_stall | w_branch_taken_e;

   always_comb begin
      if (io_pcu.match[3] && r_regw_m)      w_fwd_a = 2'b10;
      else if (io_pcu.match[1] && r_regw_w) w_fwd_a = 2'b01;
      else                                  w_fwd_a = 2'b00;
      if (io_pcu.match[2] && r_regw_m)      w_fwd_b = 2'b10;
      else if (io_pcu.match[0] && r_regw_w) w_fwd_b = 2'b01;
      else                                  w_fwd_b = 2'b00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctl_e      <= '0;
         r_regw_m     <= 1'b0;
         r_memw_m     <= 1'b0;
         r_memtoreg_m <= 1'b0;
         r_pcsrc_m    <= 1'b0;
         r_regw_w     <= 1'b0;
         r_memtoreg_w <= 1'b0;
         r_pcsrc_w    <= 1'b0;
         r_flags      <= 4'b0000;
      end else begin
         if (r_ctl_e.flagw[1] && w_condex_e) r_flags[3:2] <= io_pcu.ALUFlags[3:2];
         if (r_ctl_e.flagw[0] && w_condex_e) r_flags[1:0] <= io_pcu.ALUFlags[1:0];
         r_regw_m     <= r_ctl_e.regw & w_condex_e;
         r_memw_m     <= r_ctl_e.memw & w_condex_e;
         r_memtoreg_m <= r_ctl_e.memtoreg;
         r_pcsrc_m    <= r_ctl_e.pcsrc & w_condex_e;
         r_regw_w     <= r_regw_m;
         r_memtoreg_w <= r_memtoreg_m;
         r_pcsrc_w    <= r_pcsrc_m;
         r_ctl_e      <= w_flush_e ? '0 : w_ctl_d;
      end
   end

   assign io_pcu.RegSrcD      = w_regsrc_d;
   assign io_pcu.ImmSrcD      = w_immsrc_d;
   assign io_pcu.ALUSrcE      = r_ctl_e.alusrc;
   assign io_pcu.ALUControlE  = r_ctl_e.alu;
   assign io_pcu.BranchTakenE = w_branch_taken_e;
   assign io_pcu.MemWriteM    = r_memw_m;
   assign io_pcu.RegWriteW    = r_regw_w;
   assign io_pcu.MemtoRegW    = r_memtoreg_w;
   assign io_pcu.PCSrcW       = r_pcsrc_w;
   assign io_pcu.ForwardAE    = w_fwd_a;
   assign io_pcu.ForwardBE    = w_fwd_b;
   assign io_pcu.stallF       = w_ldr_stall | w_pcwr_pend;
   assign io_pcu.stallD       = w_ldr_stall;
   assign io_pcu.flushE       = w_flush_e;
   assign io_pcu.flushD       = w_pcwr_pend | r_pcsrc_w | w_branch_taken_e;
endmodule
